// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC delivery path: line width, sorter
// latency helper, controller state encoding and in-service stack entry.
package pic_pkg;

    localparam int unsigned PIC_N = 5;

    function automatic int unsigned sorter_latency(input int unsigned n);
        return n * (n + 1) / 2;
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StHold
    } state_e;

    typedef struct packed {
        logic [PIC_N-1:0] code;
        logic [PIC_N-1:0] pri;
    } isr_entry_t;

endpackage

// File: rtl/pic_isr_stack.sv
// In-service register stack. Push, pop, or both at once (replace top).
// Only the top entry is visible; pushes when full and pops when empty are dropped.
module pic_isr_stack
    import pic_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  isr_entry_t                   entry_i,
    output isr_entry_t                   top_o,
    output logic [$clog2(DEPTH+1)-1:0]   depth_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned DW = $clog2(DEPTH + 1);

    isr_entry_t        entries_q [DEPTH];
    isr_entry_t        entries_d [DEPTH];
    logic [DW-1:0]     depth_q, depth_d;
    logic              do_push, do_pop;
    int                wr_idx;

    assign full_o  = (depth_q == DW'(DEPTH));
    assign empty_o = (depth_q == '0);

    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        // A simultaneous pop+push overwrites the current top slot.
        wr_idx  = do_pop ? int'(depth_q) - 1 : int'(depth_q);

        entries_d = entries_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (do_push && (i == wr_idx)) begin
                entries_d[i] = entry_i;
            end
        end

        depth_d = depth_q;
        if (do_push && !do_pop) begin
            depth_d = depth_q + DW'(1);
        end else if (do_pop && !do_push) begin
            depth_d = depth_q - DW'(1);
        end
    end

    always_comb begin
        top_o = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i == int'(depth_q) - 1) begin
                top_o = entries_q[i];
            end
        end
    end

    assign depth_o = depth_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            depth_q   <= '0;
            entries_q <= '{default: '0};
        end else begin
            depth_q   <= depth_d;
            entries_q <= entries_d;
        end
    end

endmodule

// File: rtl/pic_nest_ctrl.sv
// Interrupt delivery controller: one req/ack request at a time, nested
// in-service tracking, and blanking of stale sorter results after ack/EOI.
module pic_nest_ctrl
    import pic_pkg::*;
#(
    parameter int unsigned N     = PIC_N,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT   = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         exi,
    input  logic [N-1:0]                 exi_code,
    input  logic [N-1:0]                 exi_pri,
    input  logic                         int_en,
    output logic                         int_req,
    output logic [N-1:0]                 int_code,
    input  logic                         int_ack,
    input  logic                         int_eoi,
    output logic [$clog2(DEPTH+1)-1:0]   isr_depth,
    output logic [N-1:0]                 isr_code,
    output logic                         eoi_err
);

    // Blanking is never allowed to be shorter than the sorter pipeline.
    localparam int unsigned MinLat  = sorter_latency(N) + 1;
    localparam int unsigned HoldLen = (LAT >= MinLat) ? LAT : MinLat;
    localparam int unsigned CW      = $clog2(HoldLen + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    req_code_q, req_code_d;
    logic [N-1:0]    req_pri_q, req_pri_d;
    logic            eoi_err_q, eoi_err_d;

    isr_entry_t      top;
    logic            full, empty;
    logic            push, pop, candidate;

    pic_isr_stack #(
        .DEPTH (DEPTH)
    ) u_stack (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .entry_i ('{code: req_code_q, pri: req_pri_q}),
        .top_o   (top),
        .depth_o (isr_depth),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        push      = int_ack && (state_q == StPend);
        pop       = int_eoi && !empty;
        candidate = exi && int_en && (state_q == StIdle) && !full
                    && (empty || (exi_pri < top.pri));

        state_d    = state_q;
        cnt_d      = cnt_q;
        req_code_d = req_code_q;
        req_pri_d  = req_pri_q;
        eoi_err_d  = int_eoi && empty;

        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d = StHold;
                    cnt_d   = CW'(HoldLen);
                end else if (candidate) begin
                    state_d    = StPend;
                    req_code_d = exi_code;
                    req_pri_d  = exi_pri;
                end
            end
            StPend: begin
                // A pop here leaves a lower-priority top, so the request stays valid.
                if (int_ack) begin
                    state_d = StHold;
                    cnt_d   = CW'(HoldLen);
                end
            end
            StHold: begin
                if (pop) begin
                    cnt_d = CW'(HoldLen);
                end else if (cnt_q <= CW'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            req_code_q <= '0;
            req_pri_q  <= '0;
            eoi_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_code_q <= req_code_d;
            req_pri_q  <= req_pri_d;
            eoi_err_q  <= eoi_err_d;
        end
    end

    assign int_req  = (state_q == StPend);
    assign int_code = req_code_q;
    assign isr_code = top.code;
    assign eoi_err  = eoi_err_q;

endmodule

// File: tb/tb_pic_nest_ctrl.sv
// Directed bench for pic_nest_ctrl: expected request codes are queued when a
// line is presented and compared when the controller raises int_req.
module tb_pic_nest_ctrl;

    localparam int unsigned N     = 5;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAT   = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         exi;
    logic [N-1:0] exi_code;
    logic [N-1:0] exi_pri;
    logic         int_en;
    logic         int_req;
    logic [N-1:0] int_code;
    logic         int_ack;
    logic         int_eoi;
    logic [2:0]   isr_depth;
    logic [N-1:0] isr_code;
    logic         eoi_err;

    int           n_asserts = 0;
    int           n_fail    = 0;
    int           lat;
    bit           seen;
    logic [N-1:0] exp_q [$];

    pic_nest_ctrl #(
        .N     (N),
        .DEPTH (DEPTH),
        .LAT   (LAT)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .exi       (exi),
        .exi_code  (exi_code),
        .exi_pri   (exi_pri),
        .int_en    (int_en),
        .int_req   (int_req),
        .int_code  (int_code),
        .int_ack   (int_ack),
        .int_eoi   (int_eoi),
        .isr_depth (isr_depth),
        .isr_code  (isr_code),
        .eoi_err   (eoi_err)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [N-1:0] code, input logic [N-1:0] pri);
        exi      = 1'b1;
        exi_code = code;
        exi_pri  = pri;
    endtask

    // Count cycles until int_req rises; -1 when the bound expires.
    task automatic wait_req(input int max_cycles, output int cycles);
        cycles = 0;
        while (!int_req && cycles < max_cycles) begin
            step(1);
            cycles++;
        end
        if (!int_req) cycles = -1;
    endtask

    // Wait for a request and score its code against the queue head.
    task automatic expect_req(input string tag, input int max_cycles, input int exp_lat);
        logic [N-1:0] exp_code;
        int           cyc;
        wait_req(max_cycles, cyc);
        if (exp_lat >= 0) check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_req"}, {31'd0, int_req}, 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_nonempty"}, 32'd0, 32'd1);
        end else begin
            exp_code = exp_q.pop_front();
            check({tag, "_code"}, {27'd0, int_code}, {27'd0, exp_code});
        end
    endtask

    task automatic ack_and_drop();
        int_ack = 1'b1;
        exi     = 1'b0;
        step(1);
        int_ack = 1'b0;
    endtask

    task automatic no_req_for(input string tag, input int n);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (int_req) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_int_req"},   {31'd0, int_req},   32'd0);
        check({tag, "_int_code"},  {27'd0, int_code},  32'd0);
        check({tag, "_isr_depth"}, {29'd0, isr_depth}, 32'd0);
        check({tag, "_isr_code"},  {27'd0, isr_code},  32'd0);
        check({tag, "_eoi_err"},   {31'd0, eoi_err},   32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        exi      = 1'b0;
        exi_code = '0;
        exi_pri  = '0;
        int_en   = 1'b0;
        int_ack  = 1'b0;
        int_eoi  = 1'b0;
        step(2);
        check_all_zero("reset");

        // Single delivery: line 7 pri 3, held, empty stack.
        rst    = 1'b0;
        int_en = 1'b1;
        present(5'd7, 5'd3);
        exp_q.push_back(5'd7);
        expect_req("single", 4, 1);
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
        check("single_ack_req",   {31'd0, int_req},   32'd0);
        check("single_ack_depth", {29'd0, isr_depth}, 32'd1);
        check("single_ack_top",   {27'd0, isr_code},  32'd7);
        no_req_for("single_blank", LAT);

        // Preemption by line 2 pri 1.
        present(5'd2, 5'd1);
        exp_q.push_back(5'd2);
        expect_req("preempt", 4, 1);
        ack_and_drop();
        check("preempt_depth", {29'd0, isr_depth}, 32'd2);
        check("preempt_top",   {27'd0, isr_code},  32'd2);
        int_eoi = 1'b1;
        step(1);
        int_eoi = 1'b0;
        check("preempt_eoi_depth", {29'd0, isr_depth}, 32'd1);
        check("preempt_eoi_top",   {27'd0, isr_code},  32'd7);

        // Equal and lower priority never preempt.
        present(5'd9, 5'd3);
        no_req_for("equal_pri", LAT + 4);
        present(5'd9, 5'd5);
        no_req_for("lower_pri", LAT + 4);
        exp_q.push_back(5'd9);
        int_eoi = 1'b1;
        step(1);
        int_eoi = 1'b0;
        check("lower_eoi_depth", {29'd0, isr_depth}, 32'd0);
        check("lower_eoi_top",   {27'd0, isr_code},  32'd0);
        expect_req("lower_after_eoi", LAT + 5, LAT + 1);
        ack_and_drop();

        // Stack full: four lines with rising urgency, then a pri-0 line.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            present(5'(10 + i), 5'(4 - i));
            exp_q.push_back(5'(10 + i));
            expect_req("fill", LAT + 4, -1);
            ack_and_drop();
        end
        check("full_depth", {29'd0, isr_depth}, 32'd4);
        check("full_top",   {27'd0, isr_code},  32'd13);
        present(5'd20, 5'd0);
        no_req_for("full_blocked", LAT + 4);
        exp_q.push_back(5'd20);
        int_eoi = 1'b1;
        step(1);
        int_eoi = 1'b0;
        check("full_eoi_depth", {29'd0, isr_depth}, 32'd3);
        check("full_eoi_top",   {27'd0, isr_code},  32'd12);
        expect_req("full_after_eoi", LAT + 5, LAT + 1);

        // Ack and EOI together replace the top.
        int_ack = 1'b1;
        int_eoi = 1'b1;
        exi     = 1'b0;
        step(1);
        int_ack = 1'b0;
        int_eoi = 1'b0;
        check("replace_req",   {31'd0, int_req},   32'd0);
        check("replace_depth", {29'd0, isr_depth}, 32'd3);
        check("replace_top",   {27'd0, isr_code},  32'd20);

        // Drain, then EOI on an empty stack.
        int_eoi = 1'b1;
        step(3);
        check("drain_depth", {29'd0, isr_depth}, 32'd0);
        check("drain_no_err", {31'd0, eoi_err}, 32'd0);
        step(1);
        int_eoi = 1'b0;
        check("empty_eoi_err",   {31'd0, eoi_err},   32'd1);
        check("empty_eoi_depth", {29'd0, isr_depth}, 32'd0);
        step(1);
        check("empty_eoi_pulse", {31'd0, eoi_err},   32'd0);

        // Reset while pending with two handlers stacked.
        present(5'd3, 5'd6);
        exp_q.push_back(5'd3);
        expect_req("nest_a", LAT + 4, -1);
        ack_and_drop();
        present(5'd4, 5'd2);
        exp_q.push_back(5'd4);
        expect_req("nest_b", LAT + 4, -1);
        ack_and_drop();
        present(5'd5, 5'd0);
        exp_q.push_back(5'd5);
        expect_req("nest_c", LAT + 4, -1);
        check("nest_depth", {29'd0, isr_depth}, 32'd2);
        rst = 1'b1;
        step(1);
        check_all_zero("mid_reset");
        rst = 1'b0;
        exp_q.push_back(5'd5);
        expect_req("post_reset", 4, 1);

        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
